// File: rtl/espi_mux_seq.sv
// Break-before-make sequencer for the eSPI/strap mux: disables the mux, waits a dead time,
// applies the requested PCH/BMC selects, waits a settle time, then re-enables.
module espi_mux_seq #(
    parameter int DEAD_US   = 4,
    parameter int SETTLE_US = 2,
    parameter int CNT_W     = 8,
    parameter int SWC_W     = 8
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             i1uSCE,
    input  logic             iEspiMuxPCHSel,
    input  logic             iEspiMuxBMCSel,
    output logic             oEspiMuxPCHSel,
    output logic             oEspiMuxBMCSel,
    output logic             oEspiMuxEn,
    output logic             oBusy,
    output logic [SWC_W-1:0] oSwitchCnt
);

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_STABLE = 3'd1,
        ST_BREAK  = 3'd2,
        ST_SWITCH = 3'd3,
        ST_SETTLE = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] DEAD_LAST   = CNT_W'(DEAD_US - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_US - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   timer_q, timer_d;
    logic [1:0]         sel_q, sel_d;
    logic [SWC_W-1:0]   swc_q, swc_d;
    logic               en_q;
    logic               busy_q;

    logic [1:0]         req_s;
    logic               mismatch_s;
    logic               dead_exp_s;
    logic               settle_exp_s;

    assign req_s        = {iEspiMuxPCHSel, iEspiMuxBMCSel};
    assign mismatch_s   = (req_s != sel_q);
    assign dead_exp_s   = i1uSCE && (timer_q == DEAD_LAST);
    assign settle_exp_s = i1uSCE && (timer_q == SETTLE_LAST);

    // Next-state, timer, select and counter decode
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        swc_d   = swc_q;
        if (i1uSCE) begin
            timer_d = timer_q + CNT_W'(1);
        end else begin
            timer_d = timer_q;
        end

        case (state_q)
            ST_INIT: begin
                if (settle_exp_s) begin
                    state_d = ST_STABLE;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_STABLE: begin
                timer_d = {CNT_W{1'b0}};
                if (mismatch_s) begin
                    state_d = ST_BREAK;
                end else begin
                    state_d = ST_STABLE;
                end
            end
            ST_BREAK: begin
                if (dead_exp_s) begin
                    state_d = ST_SWITCH;
                end else begin
                    state_d = ST_BREAK;
                end
            end
            ST_SWITCH: begin
                sel_d   = req_s;
                state_d = ST_SETTLE;
                if (swc_q != {SWC_W{1'b1}}) begin
                    swc_d = swc_q + SWC_W'(1);
                end else begin
                    swc_d = swc_q;
                end
            end
            ST_SETTLE: begin
                // A late request change outranks a simultaneous settle expiry
                if (mismatch_s) begin
                    state_d = ST_BREAK;
                end else if (settle_exp_s) begin
                    state_d = ST_STABLE;
                end else begin
                    state_d = ST_SETTLE;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        if (state_d != state_q) begin
            timer_d = {CNT_W{1'b0}};
        end else begin
            timer_d = timer_d;
        end
    end

    // State registers; enable and busy follow the next state so they are registered outputs
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= ST_INIT;
            timer_q <= {CNT_W{1'b0}};
            sel_q   <= 2'b00;
            swc_q   <= {SWC_W{1'b0}};
            en_q    <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            sel_q   <= sel_d;
            swc_q   <= swc_d;
            en_q    <= (state_d == ST_STABLE);
            busy_q  <= (state_d != ST_STABLE);
        end
    end

    assign oEspiMuxPCHSel = sel_q[1];
    assign oEspiMuxBMCSel = sel_q[0];
    assign oEspiMuxEn     = en_q;
    assign oBusy          = busy_q;
    assign oSwitchCnt     = swc_q;

endmodule

// File: tb/tb_espi_mux_seq.sv
// Directed bench for espi_mux_seq: sequencing timing, absorption of late requests,
// saturation of the switch counter and asynchronous reset in mid-sequence.
module tb_espi_mux_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick;
    logic       pch_i, bmc_i;
    logic       pch_o, bmc_o, en_o, busy_o;
    logic [7:0] cnt_o;
    logic [1:0] sel_o;

    int passed = 0;
    int total  = 0;
    int mon_bad = 0;
    int en_hi_cnt = 0;
    int timeouts = 0;
    int en_start;
    logic [1:0] prev_sel = 2'b00;
    logic       prev_en  = 1'b0;

    assign sel_o = {pch_o, bmc_o};

    espi_mux_seq #(.DEAD_US(4), .SETTLE_US(2), .CNT_W(8), .SWC_W(8)) dut (
        .iClk           (clk),
        .iRst_n         (rst_n),
        .i1uSCE         (tick),
        .iEspiMuxPCHSel (pch_i),
        .iEspiMuxBMCSel (bmc_i),
        .oEspiMuxPCHSel (pch_o),
        .oEspiMuxBMCSel (bmc_o),
        .oEspiMuxEn     (en_o),
        .oBusy          (busy_o),
        .oSwitchCnt     (cnt_o)
    );

    always #5 clk = ~clk;

    // Selects may only move while the mux was disabled on this and the previous cycle
    always @(negedge clk) begin
        if (rst_n === 1'b1 && sel_o !== prev_sel) begin
            if (en_o !== 1'b0 || prev_en !== 1'b0) begin
                mon_bad++;
                $display("break-before-make violation at %0t: sel %b -> %b en %b", $time, prev_sel, sel_o, en_o);
            end
        end
        if (en_o === 1'b1) en_hi_cnt++;
        prev_sel = sel_o;
        prev_en  = en_o;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic tick_pulse();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    // n tick periods of 10 clocks, ending just after the nth tick edge
    task automatic tick_periods(input int n);
        repeat (n) begin
            idle(9);
            tick_pulse();
        end
    endtask

    task automatic set_req(input logic [1:0] r);
        pch_i = r[1];
        bmc_i = r[0];
    endtask

    initial begin
        rst_n = 1'b0;
        tick  = 1'b0;
        set_req(2'b00);
        idle(3);
        chk("rst_sel", 32'(sel_o), 32'h0);
        chk("rst_en", 32'(en_o), 32'h0);
        chk("rst_busy", 32'(busy_o), 32'h1);
        chk("rst_cnt", 32'(cnt_o), 32'h0);
        rst_n = 1'b1;

        // INIT settle: enable only after the second tick
        tick_periods(1);
        chk("init_t1_en", 32'(en_o), 32'h0);
        tick_periods(1);
        chk("init_en", 32'(en_o), 32'h1);
        chk("init_busy", 32'(busy_o), 32'h0);
        chk("init_sel", 32'(sel_o), 32'h0);
        chk("init_cnt", 32'(cnt_o), 32'h0);
        idle(3);

        // Basic sequence 00 -> 10
        set_req(2'b10);
        step();
        chk("t2_break_en", 32'(en_o), 32'h0);
        chk("t2_break_busy", 32'(busy_o), 32'h1);
        chk("t2_break_sel", 32'(sel_o), 32'h0);
        tick_periods(3);
        chk("t2_dead3_sel", 32'(sel_o), 32'h0);
        tick_periods(1);
        chk("t2_switch_sel_old", 32'(sel_o), 32'h0);
        step();
        chk("t2_sel", 32'(sel_o), 32'h2);
        chk("t2_sel_en", 32'(en_o), 32'h0);
        chk("t2_cnt", 32'(cnt_o), 32'h1);
        tick_periods(1);
        chk("t2_settle1_en", 32'(en_o), 32'h0);
        tick_periods(1);
        chk("t2_en", 32'(en_o), 32'h1);
        chk("t2_busy", 32'(busy_o), 32'h0);

        // Request changes at the second BREAK tick; one switch applies the final value
        set_req(2'b01);
        step();
        tick_periods(1);
        idle(9);
        set_req(2'b11);
        tick_pulse();
        tick_periods(2);
        chk("t3_pre_switch_sel", 32'(sel_o), 32'h2);
        step();
        chk("t3_sel", 32'(sel_o), 32'h3);
        chk("t3_cnt", 32'(cnt_o), 32'h2);
        tick_periods(2);
        chk("t3_en", 32'(en_o), 32'h1);

        // Request reverts during SETTLE: full dead time again, en never high
        set_req(2'b01);
        step();
        en_start = en_hi_cnt;
        tick_periods(4);
        step();
        chk("t4_sel_first", 32'(sel_o), 32'h1);
        chk("t4_cnt_first", 32'(cnt_o), 32'h3);
        tick_periods(1);
        idle(2);
        set_req(2'b11);
        step();
        chk("t4_rebreak_busy", 32'(busy_o), 32'h1);
        tick_periods(3);
        chk("t4_dead3_sel", 32'(sel_o), 32'h1);
        tick_periods(1);
        step();
        chk("t4_sel", 32'(sel_o), 32'h3);
        chk("t4_cnt", 32'(cnt_o), 32'h4);
        tick_periods(1);
        chk("t4_en_never_high", 32'(en_hi_cnt - en_start), 32'h0);
        tick_periods(1);
        chk("t4_en", 32'(en_o), 32'h1);

        // Mismatch coinciding with settle expiry goes back to BREAK
        set_req(2'b00);
        step();
        tick_periods(4);
        step();
        chk("t5_sel_first", 32'(sel_o), 32'h0);
        tick_periods(1);
        idle(9);
        set_req(2'b11);
        tick_pulse();
        chk("t5_collide_en", 32'(en_o), 32'h0);
        chk("t5_collide_busy", 32'(busy_o), 32'h1);
        tick_periods(4);
        step();
        chk("t5_sel", 32'(sel_o), 32'h3);
        chk("t5_cnt", 32'(cnt_o), 32'h6);
        tick_periods(2);
        chk("t5_en", 32'(en_o), 32'h1);

        // Continuous ticks, 300 alternating requests: counter saturates
        tick = 1'b1;
        for (int i = 0; i < 300; i++) begin
            int k;
            set_req((i % 2 == 1) ? 2'b11 : 2'b00);
            step();
            k = 0;
            while (busy_o !== 1'b0 && k < 40) begin
                step();
                k++;
            end
            if (k >= 40) timeouts++;
        end
        chk("t6_timeouts", 32'(timeouts), 32'h0);
        chk("t6_cnt_sat", 32'(cnt_o), 32'hFF);
        chk("t6_sel", 32'(sel_o), 32'h3);
        chk("t6_en", 32'(en_o), 32'h1);
        tick = 1'b0;

        // Asynchronous reset during BREAK with req=11
        set_req(2'b00);
        step();
        tick_periods(1);
        set_req(2'b11);
        idle(3);
        rst_n = 1'b0;
        #1;
        chk("t7_rst_sel", 32'(sel_o), 32'h0);
        chk("t7_rst_en", 32'(en_o), 32'h0);
        chk("t7_rst_busy", 32'(busy_o), 32'h1);
        chk("t7_rst_cnt", 32'(cnt_o), 32'h0);
        step();
        rst_n = 1'b1;
        tick_periods(1);
        chk("t7_init_sel", 32'(sel_o), 32'h0);
        chk("t7_init_en", 32'(en_o), 32'h0);
        tick_periods(1);
        chk("t7_stable_en", 32'(en_o), 32'h1);
        chk("t7_stable_sel", 32'(sel_o), 32'h0);
        step();
        chk("t7_break_en", 32'(en_o), 32'h0);
        tick_periods(4);
        step();
        chk("t7_sel", 32'(sel_o), 32'h3);
        chk("t7_cnt", 32'(cnt_o), 32'h1);
        tick_periods(2);
        chk("t7_en", 32'(en_o), 32'h1);
        chk("t7_busy", 32'(busy_o), 32'h0);

        chk("bbm_violations", 32'(mon_bad), 32'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
